rr_burst_scheduler: RTL and testbench

- Shares one beat-oriented resource (bus/port) among N_REQ requesters.
- Each winner holds the resource for a whole burst of req_len+1 beats.
- Fairness is round-robin by masked priority: the requester above the last winner goes first, with a fallback to unmasked priority.
- Sits between requester front-ends and the shared resource, and owns grant, beat sequencing and the valid/ready handshake.

---
 rtl/rr_sched_pkg.sv | 24 ++
 rtl/rr_pick.sv | 38 +++
 rtl/rr_burst_scheduler.sv | 117 +++++++++++
 tb/tb_rr_burst_scheduler.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rr_sched_pkg.sv
// Shared definitions for the round-robin burst scheduler.
// Holds the FSM state encoding, the default requester count, and the helper
// that turns the last winner's index into the fairness mask used by the next
// arbitration.
package rr_sched_pkg;

  localparam int DEF_N_REQ = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // Mask with every bit strictly above idx set, so the requester just above
  // the previous winner gets first pick next time. Returned 32 bits wide;
  // callers truncate to their requester count (N_REQ must not exceed 32).
  // For idx=31 the shift overflows to zero, giving an all-zero mask.
  function automatic logic [31:0] mask_above(input int unsigned idx);
    logic [31:0] upto;
    upto = (32'd2 << idx) - 32'd1;
    return ~upto;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational lowest-bit-first picker with a priority mask.
// If any request survives the mask, the lowest surviving bit wins; otherwise
// the lowest raw request bit wins.
// Ports:
//   req    - raw request vector
//   mask   - priority mask (1 = preferred position)
//   onehot - one-hot winner, zero when req is zero
//   idx    - binary winner index, zero when req is zero
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    mask,
  output logic [N-1:0]    onehot,
  output logic [ID_W-1:0] idx
);

  logic [N-1:0] masked_req;
  logic [N-1:0] sel;

  assign masked_req = req & mask;
  assign sel        = (|masked_req) ? masked_req : req;

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    onehot = '0;
    idx    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (sel[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/rr_burst_scheduler.sv
// Round-robin burst scheduler.
// Shares one beat-oriented resource among N_REQ requesters. A winner keeps
// the resource for req_len+1 beats, each beat handed over with a
// valid/ready handshake. Arbitration happens only while IDLE, which leaves
// exactly one idle cycle between consecutive bursts.
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous reset, active low
//   req        - per-requester request, level-sensitive
//   req_len    - per-requester beats-minus-one, slice i for req[i]
//   grant      - registered one-hot owner
//   grant_id   - binary owner index, zero when idle
//   busy       - a burst is in progress
//   beat_valid - a beat is offered to the resource
//   beat_ready - the resource accepts the beat
//   beat_last  - current beat is the final one of the burst
module rr_burst_scheduler
  import rr_sched_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int LEN_W = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*LEN_W-1:0] req_len,
  output logic [N_REQ-1:0]       grant,
  output logic [ID_W-1:0]        grant_id,
  output logic                   busy,
  output logic                   beat_valid,
  input  logic                   beat_ready,
  output logic                   beat_last
);

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [N_REQ-1:0]   mask_q, mask_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;

  logic [N_REQ-1:0]   pick_onehot;
  logic [ID_W-1:0]    pick_idx;

  rr_pick #(
    .N    (N_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .req    (req),
    .mask   (mask_q),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      mask_q     <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      mask_q     <= mask_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
    end
  end

  // Length and owner are latched at grant time, so later changes on req or
  // req_len cannot disturb a burst in flight. cnt stops at len, so it never
  // wraps.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    mask_d     = mask_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d    = BURST;
          grant_d    = pick_onehot;
          grant_id_d = pick_idx;
          len_d      = req_len[int'(pick_idx)*LEN_W +: LEN_W];
          cnt_d      = '0;
        end
      end
      BURST: begin
        if (beat_ready) begin
          if (cnt_q == len_q) begin
            state_d    = IDLE;
            grant_d    = '0;
            grant_id_d = '0;
            cnt_d      = '0;
            mask_d     = N_REQ'(mask_above(int'(grant_id_q)));
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant      = grant_q;
  assign grant_id   = grant_id_q;
  assign busy       = (state_q == BURST);
  assign beat_valid = busy;
  assign beat_last  = busy && (cnt_q == len_q);

endmodule

// File: tb/tb_rr_burst_scheduler.sv
// Directed self-checking bench for rr_burst_scheduler (N_REQ=4, LEN_W=4).
// Inputs change and outputs are checked 1 time unit after each rising edge.
module tb_rr_burst_scheduler;

  localparam int N_REQ = 4;
  localparam int LEN_W = 4;
  localparam int ID_W  = 2;

  logic                   clk;
  logic                   rst;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*LEN_W-1:0] req_len;
  logic [N_REQ-1:0]       grant;
  logic [ID_W-1:0]        grant_id;
  logic                   busy;
  logic                   beat_valid;
  logic                   beat_ready;
  logic                   beat_last;

  int tests_run;
  int tests_failed;

  rr_burst_scheduler #(
    .N_REQ (N_REQ),
    .LEN_W (LEN_W),
    .ID_W  (ID_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_len    (req_len),
    .grant      (grant),
    .grant_id   (grant_id),
    .busy       (busy),
    .beat_valid (beat_valid),
    .beat_ready (beat_ready),
    .beat_last  (beat_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Full output check; beat_valid must always equal busy.
  task automatic check_state(input string tag, input logic [3:0] exp_grant,
                             input logic [1:0] exp_id, input logic exp_busy,
                             input logic exp_last);
    check_output({tag, "_grant"}, 32'(grant), 32'(exp_grant));
    check_output({tag, "_id"}, 32'(grant_id), 32'(exp_id));
    check_output({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    check_output({tag, "_valid"}, 32'(beat_valid), 32'(exp_busy));
    check_output({tag, "_last"}, 32'(beat_last), 32'(exp_last));
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    logic [6:0] ready_seq;
    int         exp_cnt;
    int         transfers;
    int         id;

    tests_run    = 0;
    tests_failed = 0;
    req          = '0;
    req_len      = '0;
    beat_ready   = 1'b0;
    rst          = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check_state("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    check_state("idle_noreq", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single requester, 3 beats.
    req             = 4'b0010;
    req_len[4 +: 4] = 4'd2;
    beat_ready      = 1'b1;
    tick();
    check_state("single_b1", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    check_state("single_b2", 4'b0010, 2'd1, 1'b1, 1'b0);
    tick();
    check_state("single_b3", 4'b0010, 2'd1, 1'b1, 1'b1);
    tick();
    check_state("single_done", 4'b0000, 2'd0, 1'b0, 1'b0);

    // All requesting, single-beat bursts, from a fresh mask.
    apply_reset();
    req        = 4'b1111;
    req_len    = '0;
    beat_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      id = k % 4;
      check_state($sformatf("rr_burst%0d", k), 4'(1 << id), 2'(id), 1'b1, 1'b1);
      if (k == 4) req = 4'b0000;
      tick();
      check_state($sformatf("rr_idle%0d", k), 4'b0000, 2'd0, 1'b0, 1'b0);
    end

    // Mask fallback: winner 2, then 0011 -> 0, then 1001 -> 3.
    req = 4'b0100;
    tick();
    check_state("mask_w2", 4'b0100, 2'd2, 1'b1, 1'b1);
    req = 4'b0011;
    tick();
    tick();
    check_state("mask_fallback_w0", 4'b0001, 2'd0, 1'b1, 1'b1);
    req = 4'b1001;
    tick();
    tick();
    check_state("mask_w3", 4'b1000, 2'd3, 1'b1, 1'b1);
    req = 4'b0000;
    tick();
    check_state("mask_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Backpressure: len=3, ready pattern 1,0,0,1,1,0,1.
    req             = 4'b0001;
    req_len[0 +: 4] = 4'd3;
    beat_ready      = 1'b0;
    tick();
    req       = 4'b0000;
    ready_seq = 7'b1011001;
    exp_cnt   = 0;
    transfers = 0;
    for (int k = 0; k < 7; k++) begin
      check_state($sformatf("bp_cyc%0d", k), 4'b0001, 2'd0, 1'b1, exp_cnt == 3);
      beat_ready = ready_seq[k];
      if (ready_seq[k]) begin
        transfers++;
        if (exp_cnt != 3) exp_cnt++;
      end
      tick();
    end
    check_output("bp_transfers", 32'(transfers), 32'd4);
    check_state("bp_done", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Owner drops req and rewrites its length after the first beat.
    req             = 4'b0001;
    req_len[0 +: 4] = 4'd3;
    beat_ready      = 1'b1;
    tick();
    check_state("drop_b1", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick();
    req             = 4'b0000;
    req_len[0 +: 4] = 4'd0;
    check_state("drop_b2", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick();
    check_state("drop_b3", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick();
    check_state("drop_b4", 4'b0001, 2'd0, 1'b1, 1'b1);
    tick();
    check_state("drop_done", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Reset in the middle of a burst.
    req             = 4'b0001;
    req_len[0 +: 4] = 4'd3;
    tick();
    check_state("rst_b1", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    check_state("rst_async", 4'b0000, 2'd0, 1'b0, 1'b0);
    req             = 4'b1100;
    req_len[8 +: 4] = 4'd0;
    tick();
    check_state("rst_held", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    check_state("rst_regrant", 4'b0100, 2'd2, 1'b1, 1'b1);
    req = 4'b0000;
    tick();
    check_state("rst_end", 4'b0000, 2'd0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
